// File: rtl/vrf_read_stage.sv
// -----------------------------------------------------------------------------
// vrf_read_stage
//
// Read stage between the vector-register AGU and the execute lane. It takes one
// read beat per AGU handshake and issues it to the VRF read port in the same
// cycle. The VRF returns data one cycle later. That data, together with the
// beat's byte enables and start/end flags, goes into a small FIFO. The FIFO head
// is presented to the execute lane over valid/ready.
//
// Flow control is credit based. A beat is accepted only while the queued
// entries plus the one read in flight leave room in the FIFO, so the FIFO cannot
// overflow. After the last beat of a vector is accepted, the stage drains until
// the FIFO is empty. Only then does it accept the next vector.
//
// Optional feature (compile-time macro VRD_ZERO_FILL_EN):
//   defined     - data bytes whose byte-enable bit is 0 are written to the FIFO
//                 as 8'h00
//   not defined - raw VRF data is queued and the byte enables only travel
//                 alongside it
//   Timing is the same in both builds.
//
// Parameters:
//   ADDR_W  VRF read address width
//   DATA_W  VRF read data width; the byte-enable width is DATA_W/8
//   DEPTH   output FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   agu_valid/ready   AGU beat handshake
//   agu_addr/be       beat address and byte enables
//   agu_start/end     first/last beat of vector, sampled on handshake
//   vrf_rd_en/addr    VRF read strobe and address (combinational from accept)
//   vrf_rd_data       VRF read data, valid one cycle after vrf_rd_en
//   out_valid/ready   FIFO head handshake towards the execute lane
//   out_data/be       head beat data and byte enables
//   out_start/end     head beat is first/last of vector
//   busy              stage is not idle
// -----------------------------------------------------------------------------
module vrf_read_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                agu_valid,
    output logic                agu_ready,
    input  logic [ADDR_W-1:0]   agu_addr,
    input  logic [DATA_W/8-1:0] agu_be,
    input  logic                agu_start,
    input  logic                agu_end,
    output logic                vrf_rd_en,
    output logic [ADDR_W-1:0]   vrf_rd_addr,
    input  logic [DATA_W-1:0]   vrf_rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_be,
    output logic                out_start,
    output logic                out_end,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

`ifdef VRD_ZERO_FILL_EN
    // Zero every data byte whose byte enable is clear.
    function automatic logic [DATA_W-1:0] zero_fill(input logic [DATA_W-1:0] d,
                                                    input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = {DATA_W{1'b0}};
        for (int i = 0; i < BE_W; i++) begin
            res[i*8 +: 8] = be[i] ? d[i*8 +: 8] : 8'h00;
        end
        return res;
    endfunction
`endif

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic               inflight_r;

    // Side pipe: beat attributes that travel with the outstanding read.
    logic [BE_W-1:0]    be_p_r;
    logic               start_p_r;
    logic               end_p_r;

    logic [DATA_W-1:0]  data_mem_r  [DEPTH];
    logic [BE_W-1:0]    be_mem_r    [DEPTH];
    logic               start_mem_r [DEPTH];
    logic               end_mem_r   [DEPTH];

    logic [CNT_W:0]     occ_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               out_valid_s;
    logic [PTR_W-1:0]   head_idx_s;
    logic [DATA_W-1:0]  push_data_s;

    // The FIFO occupancy, the in-flight read, the drain state and the credit
    // limit together give the handshake, read strobe and push/pop controls.
    always_comb begin
        occ_s       = {1'b0, cnt_r} + {{CNT_W{1'b0}}, inflight_r};
        agu_ready   = (state_r != ST_DRAIN) && (occ_s < OCC_LIMIT);
        accept_s    = agu_valid && agu_ready;
        vrf_rd_en   = accept_s;
        vrf_rd_addr = accept_s ? agu_addr : {ADDR_W{1'b0}};
        push_s      = inflight_r;
        out_valid_s = (cnt_r != CNT_ZERO);
        pop_s       = out_valid_s && out_ready;
    end

    // Data written into the FIFO, masked by the byte enables when the option is enabled.
    always_comb begin
`ifdef VRD_ZERO_FILL_EN
        push_data_s = zero_fill(vrf_rd_data, be_p_r);
`else
        push_data_s = vrf_rd_data;
`endif
    end

    // When the FIFO is empty, the outputs show the slot just behind the read pointer.
    // That slot holds the last popped beat and is not overwritten while the FIFO is
    // empty, so the outputs keep the last popped values.
    always_comb begin
        if (out_valid_s) begin
            head_idx_s = rd_ptr_r;
        end else begin
            head_idx_s = rd_ptr_r - PTR_ONE;
        end
        out_valid = out_valid_s;
        out_data  = data_mem_r[head_idx_s];
        out_be    = be_mem_r[head_idx_s];
        out_start = start_mem_r[head_idx_s];
        out_end   = end_mem_r[head_idx_s];
        busy      = (state_r != ST_IDLE);
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = agu_end ? ST_DRAIN : ST_STREAM;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s && agu_end) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                // Leave only when no read is outstanding and the last entry is gone
                // (or leaves this cycle).
                if (!inflight_r && ((cnt_r == CNT_ZERO) || ((cnt_r == CNT_ONE) && pop_s))) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Side pipe: the in-flight flag plus the accepted beat's attributes.
    // The first beat taken in IDLE always opens a vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_r <= 1'b0;
            be_p_r     <= {BE_W{1'b0}};
            start_p_r  <= 1'b0;
            end_p_r    <= 1'b0;
        end else begin
            inflight_r <= accept_s;
            if (accept_s) begin
                be_p_r    <= agu_be;
                start_p_r <= agu_start || (state_r == ST_IDLE);
                end_p_r   <= agu_end;
            end
        end
    end

    // FIFO storage: the returned read is written at the write pointer in the
    // capture cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i]  <= {DATA_W{1'b0}};
                be_mem_r[i]    <= {BE_W{1'b0}};
                start_mem_r[i] <= 1'b0;
                end_mem_r[i]   <= 1'b0;
            end
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r]  <= push_data_s;
                be_mem_r[wr_ptr_r]    <= be_p_r;
                start_mem_r[wr_ptr_r] <= start_p_r;
                end_mem_r[wr_ptr_r]   <= end_p_r;
            end
        end
    end

    // FIFO pointers and count. The pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule
